dff_bank_arbiter: RTL

Round-robin arbiter and sequencer for a shared WIDTH-bit register bank built from clear/preset D flip-flops. Four requesters issue write/clear/preset/toggle operations through a req/gnt handshake. The block grants exactly one requester per access cycle and applies that requester's operation to the bank. It sits between the requester logic and the register bank and is the only writer of the bank.

---
 rtl/dff_bank_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
// Round-robin arbiter for four requesters sharing one WIDTH-bit register bank.
// An IDLE cycle picks a winner and a GRANT cycle applies its operation
// (write/clear/preset/toggle) to the bank. A locking requester can keep the
// grant for up to MAX_BURST consecutive GRANT cycles.
module dff_bank_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [3:0]           req,
  input  logic [3:0]           lock,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   wdata,
  output logic [3:0]           gnt,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 busy,
  output logic [1:0]           last_id
);

  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST - 1);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          gnt_reg, gnt_next;
  logic [WIDTH-1:0]    q_reg, q_next;
  logic [1:0]          ptr_reg, ptr_next;
  logic [BCNT_W-1:0]   bcnt_reg, bcnt_next;
  logic [1:0]          last_id_reg, last_id_next;

  // Per-requester views of the packed operand buses
  logic [1:0]          op_arr    [4];
  logic [WIDTH-1:0]    wdata_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign op_arr[gi]    = op[2*gi +: 2];
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotate requests so that bit 0 is the requester at ptr, then take the
  // first set bit; the winner is ptr plus that offset, wrapping mod 4.
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] win_ofs;
  logic [1:0] win;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_reg +: 4];

  // Priority pick over the rotated request vector
  always_comb begin
    win_ofs = 2'd0;
    if (req_rot[0])      win_ofs = 2'd0;
    else if (req_rot[1]) win_ofs = 2'd1;
    else if (req_rot[2]) win_ofs = 2'd2;
    else if (req_rot[3]) win_ofs = 2'd3;
  end

  assign win = ptr_reg + win_ofs;

  // Next-state logic: arbitration in IDLE, op application and burst control in GRANT
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    q_next       = q_reg;
    ptr_next     = ptr_reg;
    bcnt_next    = bcnt_reg;
    last_id_next = last_id_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = 4'b0000;
        if (|req) begin
          gnt_next     = 4'b0001 << win;
          last_id_next = win;
          bcnt_next    = '0;
          state_next   = GRANT;
        end
      end
      GRANT: begin
        // A dropped request cancels the access; q is simply held.
        if (req[last_id_reg]) begin
          case (op_arr[last_id_reg])
            OP_WRITE:  q_next = wdata_arr[last_id_reg];
            OP_CLEAR:  q_next = '0;
            OP_PRESET: q_next = '1;
            OP_TOGGLE: q_next = ~q_reg;
            default:   q_next = q_reg;
          endcase
        end
        if (lock[last_id_reg] && req[last_id_reg] && (bcnt_reg < BCNT_MAX)) begin
          bcnt_next = bcnt_reg + 1'b1;
        end else begin
          gnt_next   = 4'b0000;
          ptr_next   = last_id_reg + 2'd1;
          state_next = IDLE;
        end
      end
      default: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // State registers; clr low aborts any pending access immediately
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= IDLE;
      gnt_reg     <= 4'b0000;
      q_reg       <= '0;
      ptr_reg     <= 2'd0;
      bcnt_reg    <= '0;
      last_id_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      q_reg       <= q_next;
      ptr_reg     <= ptr_next;
      bcnt_reg    <= bcnt_next;
      last_id_reg <= last_id_next;
    end
  end

  assign gnt     = gnt_reg;
  assign q       = q_reg;
  assign qbar    = ~q_reg;
  assign busy    = (state_reg == GRANT);
  assign last_id = last_id_reg;

endmodule
